// File: rtl/mont_ft_mul.sv
// Word-serial Montgomery multiplier (CIOS-style MAC per word) with fault detection:
// the product is computed twice with operands swapped, and the two results are compared.
module mont_ft_mul #(
  parameter int SIZE = 1024,
  parameter int WORD = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WORD-1:0] in_data,
  input  logic            fault_inj,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WORD-1:0] out_data,
  output logic            out_last,
  output logic            fault,
  output logic            busy
);

  localparam int ITER = SIZE / WORD;
  localparam int TW   = SIZE + WORD + 1;
  localparam int MW   = 2 * WORD + 1;
  localparam int IW   = $clog2(ITER + 1);
  localparam int IXW  = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [IW-1:0] ITER_C = IW'(ITER);
  localparam logic [IW-1:0] LAST_C = IW'(ITER - 1);

  typedef enum logic [2:0] {IDLE, LOAD, MCALC, ACC, SUB, SWAP, CMP, OUT} state_t;
  state_t state, state_nx;

  logic [ITER-1:0][WORD-1:0] n_r, u_r, v_r, r1, r2;
  logic [WORD-1:0]           np_r, m_r;
  logic [TW-1:0]             t_r;
  logic [WORD:0]             carry_r;
  logic [1:0]                ld_sel;
  logic [IW-1:0]             ld_w, i_cnt, j_cnt, o_idx;
  logic                      pass2, flt, inj_pend;

  logic [IXW-1:0] i_ix, j_ix, o_ix, ld_ix;
  logic [WORD-1:0] u_i, v_j, n_j, t_j, m_nx;
  logic [MW-1:0]   mac;
  logic [WORD:0]   hi_sum;
  logic [TW-1:0]   t_pre, t_shift, n_ext, two_n;
  logic [SIZE-1:0] t_sub, res;
  logic            inj;

  assign i_ix  = i_cnt[IXW-1:0];
  assign j_ix  = j_cnt[IXW-1:0];
  assign o_ix  = o_idx[IXW-1:0];
  assign ld_ix = ld_w[IXW-1:0];

  assign u_i = u_r[i_ix];
  assign v_j = v_r[j_ix];
  assign n_j = n_r[j_ix];
  assign t_j = t_r[j_ix*WORD +: WORD];

  // All operands WORD wide: the arithmetic wraps mod 2^WORD naturally.
  assign m_nx = (t_r[WORD-1:0] + u_i * v_r[0]) * np_r;

  // t_j + u_i*v_j + m*N_j + carry stays below 2^(2*WORD+1), so carry fits WORD+1 bits.
  assign mac = MW'(t_j) + MW'(u_i) * MW'(v_j) + MW'(m_r) * MW'(n_j) + MW'(carry_r);

  assign hi_sum  = t_r[TW-1:SIZE] + carry_r;
  assign t_pre   = {hi_sum, t_r[SIZE-1:0]};
  assign t_shift = t_pre >> WORD;
  assign inj     = pass2 && (inj_pend || fault_inj);

  assign n_ext = {{(WORD+1){1'b0}}, n_r};
  assign two_n = {{WORD{1'b0}}, n_r, 1'b0};
  assign t_sub = t_r[SIZE-1:0] - n_r;
  assign res   = (t_r >= n_ext) ? t_sub : t_r[SIZE-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = LOAD;
      LOAD:  if (in_valid && ld_sel == 2'd3) state_nx = MCALC;
      MCALC: state_nx = ACC;
      ACC:   if (j_cnt == ITER_C) state_nx = (i_cnt == LAST_C) ? SUB : MCALC;
      SUB:   state_nx = pass2 ? CMP : SWAP;
      SWAP:  state_nx = MCALC;
      CMP:   state_nx = OUT;
      OUT:   if (out_ready && o_idx == LAST_C) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_r      <= '0;
      u_r      <= '0;
      v_r      <= '0;
      r1       <= '0;
      r2       <= '0;
      np_r     <= '0;
      m_r      <= '0;
      t_r      <= '0;
      carry_r  <= '0;
      ld_sel   <= '0;
      ld_w     <= '0;
      i_cnt    <= '0;
      j_cnt    <= '0;
      o_idx    <= '0;
      pass2    <= 1'b0;
      flt      <= 1'b0;
      inj_pend <= 1'b0;
    end else begin
      case (state)
        LOAD: if (in_valid) begin
          case (ld_sel)
            2'd0:    n_r[ld_ix] <= in_data;
            2'd1:    u_r[ld_ix] <= in_data;
            2'd2:    v_r[ld_ix] <= in_data;
            default: np_r       <= in_data;
          endcase
          if (ld_sel == 2'd3) begin
            ld_sel   <= '0;
            ld_w     <= '0;
            t_r      <= '0;
            i_cnt    <= '0;
            j_cnt    <= '0;
            carry_r  <= '0;
            pass2    <= 1'b0;
            inj_pend <= 1'b0;
          end else if (ld_w == LAST_C) begin
            ld_w   <= '0;
            ld_sel <= ld_sel + 2'd1;
          end else begin
            ld_w <= ld_w + 1'b1;
          end
        end
        MCALC: begin
          m_r     <= m_nx;
          j_cnt   <= '0;
          carry_r <= '0;
        end
        ACC: begin
          if (j_cnt == ITER_C) begin
            // Word 0 is zero by choice of m; the shift is the divide by 2^WORD.
            t_r      <= t_shift ^ TW'(inj);
            i_cnt    <= i_cnt + 1'b1;
            j_cnt    <= '0;
            carry_r  <= '0;
            inj_pend <= 1'b0;
          end else begin
            t_r[j_ix*WORD +: WORD] <= mac[WORD-1:0];
            carry_r <= mac[MW-1:WORD];
            j_cnt   <= j_cnt + 1'b1;
            if (pass2 && fault_inj) inj_pend <= 1'b1;
          end
        end
        SUB: begin
          // A correct reduction always leaves t < 2N; anything else is a fault.
          if (t_r >= two_n) flt <= 1'b1;
          if (pass2) r2 <= res;
          else       r1 <= res;
        end
        SWAP: begin
          u_r     <= v_r;
          v_r     <= u_r;
          t_r     <= '0;
          i_cnt   <= '0;
          j_cnt   <= '0;
          carry_r <= '0;
          pass2   <= 1'b1;
        end
        CMP: begin
          if (r1 != r2) flt <= 1'b1;
          o_idx <= '0;
        end
        OUT: if (out_ready) begin
          if (o_idx == LAST_C) begin
            flt   <= 1'b0;
            r1    <= '0;
            r2    <= '0;
            o_idx <= '0;
          end else begin
            o_idx <= o_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == OUT);
  assign out_last  = out_valid && (o_idx == LAST_C);
  assign fault     = out_valid && flt;
  assign out_data  = (out_valid && !flt) ? r1[o_ix] : '0;
  assign busy      = (state != IDLE) && (state != LOAD);

endmodule

// File: tb/tb_mont_ft_mul.sv
// Bench for mont_ft_mul: SIZE=64, WORD=16, N=2^64-59; result checked against a
// plain-arithmetic Montgomery model (u*v*2^-64 mod N) by a per-cycle output monitor.
module tb_mont_ft_mul;
  localparam int SIZE = 64;
  localparam int WORD = 16;
  localparam logic [63:0] NMOD = 64'hFFFF_FFFF_FFFF_FFC5;
  localparam logic [15:0] NP   = 16'hD8F3;

  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, fault_inj = 1'b0, out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic in_ready, out_valid, out_last, fault, busy;
  logic [15:0] out_data;

  int checks = 0, failures = 0, acc_cnt = 0, ops_done = 0, widx = 0;
  logic [63:0] exp_res_q[$];
  bit          exp_flt_q[$];
  logic        stalled = 1'b0, prev_last, prev_fault;
  logic [15:0] prev_data, ew;
  logic [63:0] er;

  always #5 clk = ~clk;

  mont_ft_mul #(.SIZE(SIZE), .WORD(WORD)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .fault_inj(fault_inj), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .fault(fault), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // u*v*2^-64 mod N via modular product then 64 halvings mod N.
  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [64:0]  x;
    p = ({64'h0, a} * {64'h0, b}) % {64'h0, NMOD};
    x = {1'b0, p[63:0]};
    for (int k = 0; k < 64; k++)
      x = x[0] ? ((x + {1'b0, NMOD}) >> 1) : (x >> 1);
    return x[63:0];
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      widx    = 0;
      stalled = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_cnt++;
      if (out_valid) begin
        if (exp_res_q.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          er = exp_res_q[0];
          ew = exp_flt_q[0] ? 16'h0 : er[widx*16 +: 16];
          chk("out_data", out_data, ew);
          chk("out_last", out_last, widx == 3);
          chk("fault", fault, exp_flt_q[0]);
          chk("in_ready_in_out", in_ready, 0);
          if (stalled) begin
            chk("stall_data", out_data, prev_data);
            chk("stall_last", out_last, prev_last);
            chk("stall_fault", fault, prev_fault);
          end
          if (out_ready) begin
            stalled = 1'b0;
            widx++;
            if (widx == 4) begin
              widx = 0;
              void'(exp_res_q.pop_front());
              void'(exp_flt_q.pop_front());
              ops_done++;
            end
          end else begin
            stalled    = 1'b1;
            prev_data  = out_data;
            prev_last  = out_last;
            prev_fault = fault;
          end
        end
      end
    end
  end

  task automatic do_load(input logic [63:0] u, input logic [63:0] v, input bit gap);
    logic [15:0] w [13];
    logic [63:0] nm;
    int cnt;
    nm = NMOD;
    for (int k = 0; k < 4; k++) begin
      w[k]     = nm[k*16 +: 16];
      w[k + 4] = u[k*16 +: 16];
      w[k + 8] = v[k*16 +: 16];
    end
    w[12] = NP;
    for (int k = 0; k < 13; k++) begin
      if (gap && k == 5) begin
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_data  = w[k];
      cnt = 0;
      @(negedge clk);
      while (!in_ready && cnt < 50) begin @(negedge clk); cnt++; end
      if (cnt >= 50) chk("load_timeout", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [63:0] u, input logic [63:0] v,
                        input bit gap, input bit inj, input bit rmode, input bit lat);
    int cnt, cyc, target;
    fault_inj = inj;
    exp_res_q.push_back(model(u, v));
    exp_flt_q.push_back(inj);
    acc_cnt   = 0;
    out_ready = !rmode;
    do_load(u, v, gap);
    chk("load_count", acc_cnt, 13);
    chk("in_ready_drop", in_ready, 0);
    chk("busy_calc", busy, 1);
    if (gap) begin
      in_valid = 1'b1;
      in_data  = 16'hBEEF;
    end
    cnt = 0;
    while (!out_valid && cnt < 300) begin @(posedge clk); #1; cnt++; end
    chk("out_timeout", cnt < 300, 1);
    if (lat) chk("latency", cnt, 52);
    in_valid = 1'b0;
    target = ops_done + 1;
    cyc = 0;
    while (ops_done < target && cyc < 200) begin
      out_ready = rmode ? (cyc % 3 == 0) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    chk("drain_timeout", ops_done >= target, 1);
    chk("load_count_final", acc_cnt, 13);
    out_ready = 1'b0;
    fault_inj = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_fault", fault, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Pin the model: 59 = 2^64 mod N, so model(59, v) must give v.
    chk("model_59_12345", model(64'd59, 64'd12345), 64'd12345);
    chk("model_59_59", model(64'd59, 64'd59), 64'd59);
    chk("model_0_nm1", model(64'd0, NMOD - 64'd1), 64'd0);
    chk("model_59_7", model(64'd59, 64'd7), 64'd7);

    run_op(64'd59, 64'd12345, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(64'd59, 64'd59, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(64'd0, NMOD - 64'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(64'd59, 64'd12345, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op(64'd59, 64'd7, 1'b0, 1'b0, 1'b1, 1'b0);

    // Abort mid pass-1 ACC; no expected entry is queued, so any output is spurious.
    do_load(64'd59, 64'd12345, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    chk("busy_pre_abort", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_fault", fault, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_out_last", out_last, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    run_op(64'd59, 64'd5, 1'b0, 1'b0, 1'b0, 1'b0);

    run_op(64'd59, 64'd12345, 1'b1, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mont_ft_mul.md
MONT_FT_MUL -- requirements
Module: mont_ft_mul

Interface
REQ-001 The block SHALL have parameter SIZE, default 1024, giving the operand width in bits; SIZE SHALL be a multiple of WORD.
REQ-002 The block SHALL have parameter WORD, default 64, giving the datapath and bus word width; ITER = SIZE/WORD.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  in_data holds a valid load word.
REQ-006 in_ready  output  1  block accepts a load word this cycle.
REQ-007 in_data  input  WORD  load word.
REQ-008 fault_inj  input  1  test hook: corrupt the second pass.
REQ-009 out_valid  output  1  out_data holds a valid result word.
REQ-010 out_ready  input  1  consumer accepts the result word.
REQ-011 out_data  output  WORD  result word, least-significant word (LSW) first.
REQ-012 out_last  output  1  marks the final (ITER-th) result word.
REQ-013 fault  output  1  fault detected on the current result; held for the whole output phase.
REQ-014 busy  output  1  high in every state except IDLE and LOAD.

Function
REQ-015 States SHALL be IDLE, LOAD, MCALC, ACC, SUB, SWAP, CMP and OUT.
- IDLE goes to LOAD unconditionally on the next cycle.
REQ-016 In LOAD, in_ready SHALL be 1 and exactly 3*ITER+1 words SHALL be accepted, one per in_valid&&in_ready cycle, in this order:
- modulus N, ITER words, LSW first
- u, ITER words, LSW first
- v, ITER words, LSW first
- n_prime, one word
REQ-017 After the last load word is accepted, in_ready SHALL drop in the next cycle and the FSM SHALL enter MCALC with i=0 and t=0.
REQ-018 Preconditions, not checked by the block: N is odd; n_prime = -N^-1 mod 2^WORD; u<N; v<N.
REQ-019 MCALC SHALL take 1 cycle and compute m = ((t[WORD-1:0] + u_i*v[WORD-1:0]) * n_prime) mod 2^WORD.
REQ-020 ACC SHALL take ITER+1 cycles.
- Cycle j performs one WORDxWORD multiply-accumulate of u_i*v_j + m*N_j into t, with carry.
- After the last cycle, t = (t + u_i*v + m*N) >> WORD, and i increments.
REQ-021 Internal t SHALL be SIZE+WORD+1 bits wide so that no overflow occurs.
REQ-022 After ACC, if i<ITER the FSM SHALL return to MCALC, else go to SUB.
REQ-023 SUB SHALL take 1 cycle and apply these rules:
- if t>=2N, set the internal fault bit (invariant violation);
- else if t>=N, result = t-N;
- else result = t.
REQ-024 One pass SHALL therefore take ITER*(ITER+2)+1 cycles.
REQ-025 The first pass SHALL store its result in R1; SWAP (1 cycle) SHALL then exchange u and v, clear t and i, and rerun MCALC/ACC/SUB as pass 2, storing R2.
REQ-026 When fault_inj is high in any pass-2 ACC cycle, bit 0 of t SHALL be inverted at the end of that pass-2 iteration.
REQ-027 CMP (1 cycle) SHALL set the fault bit if R1!=R2, then enter OUT.
- Total latency from the last load word to the first out_valid is 2*(ITER*(ITER+2)+1)+2 cycles.
REQ-028 In OUT, out_valid SHALL be 1 and ITER words SHALL be emitted LSW first; a word advances only on out_valid&&out_ready.
- out_last is 1 on word ITER-1.
- While fault=1, every out_data word SHALL be 0.
REQ-029 While out_ready is low, out_data, out_last and fault SHALL remain stable.
REQ-030 After the last word is accepted, the FSM SHALL clear the fault bit, R1 and R2, and return to IDLE.
- The next operation SHALL be independent of the previous one.
REQ-031 in_valid SHALL be ignored outside LOAD; out_ready SHALL be ignored outside OUT.
REQ-032 fault_inj SHALL be ignored outside pass-2 ACC.

Reset
REQ-033 While reset is high, the block SHALL set state=IDLE and the following outputs:
- in_ready=0, out_valid=0, out_last=0, out_data=0, fault=0, busy=0.
REQ-034 While reset is high, all counters and the t, u, v, N, n_prime, R1 and R2 registers SHALL be 0.
REQ-035 Reset asserted in any state, including mid-LOAD, mid-ACC or mid-OUT, SHALL abort the operation with no partial output; after release the block SHALL restart in IDLE and require a full reload.

Verification
All scenarios use SIZE=64, WORD=16, ITER=4, N=2^64-59 and n_prime=0xD8F3.
REQ-036 Load u=59, v=12345 with out_ready=1 -> first out_valid exactly 52 cycles after the last load word; words 0x3039,0,0,0; fault=0; out_last on the 4th word.
REQ-037 Load u=59, v=59 -> result 59; then u=0, v=N-1 with no reset in between -> result 0, fault=0.
REQ-038 u=59, v=12345 with fault_inj=1 throughout -> fault=1 for all 4 words; out_data=0 on all 4 words.
REQ-039 u=59, v=7 with out_ready toggling 1 cycle on, 2 cycles off -> words 7,0,0,0 delivered in order; outputs stable while stalled; in_ready=0 throughout OUT.
REQ-040 Assert reset during pass-1 ACC, then do a fresh load of u=59, v=5 -> result 5, fault=0, and no output words before the fresh load completes.
REQ-041 Hold in_valid=0 for 3 cycles mid-LOAD, with in_valid asserted outside LOAD -> exactly 13 words accepted; correct result 12345 for the u=59, v=12345 set.
